// File: rtl/box_anim_pkg.sv
// Shared types and constants for the bouncing-box animator.
package box_anim_pkg;

  typedef enum logic [3:0] {
    CLEAR_REQ, CLEAR_REL, IDLE, WAIT_FRAME,
    ERASE_LX, ERASE_LX_REL, ERASE_PY, ERASE_PY_REL,
    MOVE,
    DRAW_LX, DRAW_LX_REL, DRAW_PY, DRAW_PY_REL
  } state_t;

  localparam int BOX_SIZE      = 4;
  localparam int STROBE_CYCLES = 2;

  // One axis of motion: origin plus direction (neg=1 means stepping down).
  typedef struct packed {
    logic       neg;
    logic [6:0] pos;
  } axis_t;

  // Edge checks come before the step so the origin never wraps.
  function automatic axis_t axis_step(axis_t a, logic [6:0] range);
    axis_t r;
    r = a;
    if (!a.neg && a.pos == range) begin
      r.neg = 1'b1;
      r.pos = a.pos - 7'd1;
    end else if (a.neg && a.pos == 7'd0) begin
      r.neg = 1'b0;
      r.pos = 7'd1;
    end else if (a.neg) begin
      r.pos = a.pos - 7'd1;
    end else begin
      r.pos = a.pos + 7'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/box_animator_frame_tick_gen.sv
// Free-running frame divider: frame_tick every FRAME_CYCLES clocks,
// move_tick on every FRAMES_PER_MOVE-th frame_tick.
module frame_tick_gen #(
  parameter int FRAME_CYCLES    = 833333,
  parameter int FRAMES_PER_MOVE = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic frame_tick_o,
  output logic move_tick_o
);

  localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int FW = (FRAMES_PER_MOVE > 1) ? $clog2(FRAMES_PER_MOVE) : 1;

  logic [CW-1:0] cyc_q;
  logic [FW-1:0] frm_q;

  assign frame_tick_o = (cyc_q == CW'(FRAME_CYCLES - 1));
  assign move_tick_o  = frame_tick_o && (frm_q == FW'(FRAMES_PER_MOVE - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cyc_q <= '0;
      frm_q <= '0;
    end else begin
      cyc_q <= frame_tick_o ? '0 : cyc_q + CW'(1);
      if (frame_tick_o) frm_q <= move_tick_o ? '0 : frm_q + FW'(1);
    end
  end

endmodule

// File: rtl/box_animator.sv
// Sequencer for the 4x4 box plotter: clears the screen, then erases/moves/redraws
// one box per move_tick, bouncing it off the screen edges.
module box_animator
  import box_anim_pkg::*;
#(
  parameter int         FRAME_CYCLES    = 833333,
  parameter int         FRAMES_PER_MOVE = 15,
  parameter logic [6:0] X_RANGE         = 7'(128 - BOX_SIZE),
  parameter logic [6:0] Y_RANGE         = 7'(120 - BOX_SIZE),
  parameter logic [6:0] X_INIT          = 7'd0,
  parameter logic [6:0] Y_INIT          = 7'd0
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic       iEnable,
  input  logic [2:0] iColour,
  input  logic       iDone,
  output logic [6:0] oXY_Coord,
  output logic [2:0] oColour,
  output logic       oLoadX,
  output logic       oPlotBox,
  output logic       oBlack,
  output logic       oBusy
);

  state_t     state_q, state_d;
  logic [1:0] cnt_q;
  logic       first_q;
  axis_t      xa_q, ya_q, xa_d, ya_d;
  logic [2:0] draw_col_q;
  logic       frame_tick, move_tick;
  logic [6:0] coord_d, xy_q;
  logic [2:0] pcol_d, col_q;
  logic       loadx_q, plot_q, black_q, busy_q;

  frame_tick_gen #(
    .FRAME_CYCLES   (FRAME_CYCLES),
    .FRAMES_PER_MOVE(FRAMES_PER_MOVE)
  ) u_tick (
    .clk_i       (iClock),
    .rst_i       (iReset),
    .frame_tick_o(frame_tick),
    .move_tick_o (move_tick)
  );

  // CLEAR_REQ spends its first cycle filling the output registers, so the
  // exit point is one count later than the pass strobes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR_REQ:    if (cnt_q == 2'(STROBE_CYCLES)) state_d = CLEAR_REL;
      CLEAR_REL:    if (iDone) state_d = IDLE;
      IDLE:         if (iEnable) state_d = WAIT_FRAME;
      WAIT_FRAME: begin
        if (!iEnable)                     state_d = IDLE;
        else if (frame_tick && move_tick) state_d = first_q ? DRAW_LX : ERASE_LX;
      end
      ERASE_LX:     if (cnt_q == 2'(STROBE_CYCLES - 1)) state_d = ERASE_LX_REL;
      ERASE_LX_REL: state_d = ERASE_PY;
      ERASE_PY:     if (cnt_q == 2'(STROBE_CYCLES - 1)) state_d = ERASE_PY_REL;
      ERASE_PY_REL: if (iDone) state_d = MOVE;
      MOVE:         state_d = DRAW_LX;
      DRAW_LX:      if (cnt_q == 2'(STROBE_CYCLES - 1)) state_d = DRAW_LX_REL;
      DRAW_LX_REL:  state_d = DRAW_PY;
      DRAW_PY:      if (cnt_q == 2'(STROBE_CYCLES - 1)) state_d = DRAW_PY_REL;
      DRAW_PY_REL:  if (iDone) state_d = WAIT_FRAME;
      default:      state_d = CLEAR_REQ;
    endcase
  end

  assign xa_d = (state_q == MOVE) ? axis_step(xa_q, X_RANGE) : xa_q;
  assign ya_d = (state_q == MOVE) ? axis_step(ya_q, Y_RANGE) : ya_q;

  // Outputs are registered from state_d so they line up with state_q.
  always_comb begin
    coord_d = '0;
    pcol_d  = '0;
    case (state_d)
      ERASE_LX, ERASE_LX_REL, DRAW_LX, DRAW_LX_REL: coord_d = xa_d.pos;
      ERASE_PY, ERASE_PY_REL:                       coord_d = ya_d.pos;
      DRAW_PY, DRAW_PY_REL: begin
        coord_d = ya_d.pos;
        pcol_d  = draw_col_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q    <= CLEAR_REQ;
      cnt_q      <= '0;
      first_q    <= 1'b1;
      xa_q       <= axis_t'{neg: 1'b0, pos: X_INIT};
      ya_q       <= axis_t'{neg: 1'b0, pos: Y_INIT};
      draw_col_q <= '0;
      xy_q       <= '0;
      col_q      <= '0;
      loadx_q    <= 1'b0;
      plot_q     <= 1'b0;
      black_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? 2'd0 : cnt_q + 2'd1;
      xa_q    <= xa_d;
      ya_q    <= ya_d;
      if (state_q == DRAW_PY_REL && iDone) first_q <= 1'b0;
      if (state_d == DRAW_LX && state_q != DRAW_LX) draw_col_q <= iColour;
      xy_q    <= coord_d;
      col_q   <= pcol_d;
      loadx_q <= state_d inside {ERASE_LX, DRAW_LX};
      plot_q  <= state_d inside {ERASE_PY, DRAW_PY};
      black_q <= (state_d == CLEAR_REQ);
      busy_q  <= !(state_d inside {IDLE, WAIT_FRAME});
    end
  end

  assign oXY_Coord = xy_q;
  assign oColour   = col_q;
  assign oLoadX    = loadx_q;
  assign oPlotBox  = plot_q;
  assign oBlack    = black_q;
  assign oBusy     = busy_q;

endmodule

// File: doc/box_animator.md
Name: box_animator

Overview:
- Upstream sequencer for the 4x4 box plotter: it generates the plotter's iLoadX/iPlotBox/iXY_Coord/iColour stimulus and consumes its oDone.
- Moves one box diagonally across the screen, bouncing off the edges.
- Each move is one erase pass (colour 0 at the old position), one position update, and one draw pass (iColour at the new position).
- Moves are paced by an internal frame divider.

Parameters:
- FRAME_CYCLES, 833333: clock cycles per frame tick (60 Hz at 50 MHz).
- FRAMES_PER_MOVE, 15: frame ticks between moves.
- X_RANGE, 7'd124: maximum box X origin. The box stays inside 128 columns because of the 7-bit coordinate bus.
- Y_RANGE, 7'd116: maximum box Y origin (120 - 4).
- X_INIT, 7'd0: X origin after reset.
- Y_INIT, 7'd0: Y origin after reset.

Ports:
- iClock  in  1  system clock. All logic is on one clock, rising edge.
- iReset  in  1  asynchronous, active-high reset.
- iEnable  in  1  run request (level).
- iColour  in  3  draw colour, sampled at the start of each draw pass.
- iDone  in  1  plotter frame-done pulse.
- oXY_Coord  out  7  coordinate to plotter.
- oColour  out  3  colour to plotter.
- oLoadX  out  1  plotter X-load strobe.
- oPlotBox  out  1  plotter Y/colour-load and plot strobe.
- oBlack  out  1  plotter clear-screen request.
- oBusy  out  1  high in every state except IDLE and WAIT_FRAME.

Behaviour:
- Reset: iReset is asynchronous, active-high. It forces all outputs to 0, the state to CLEAR_REQ, x to X_INIT, y to Y_INIT, dx to +1, dy to +1, the frame counters to 0, and the first flag to 1.
- Reset mid-operation aborts any pass immediately with no completion.

State machine:
- CLEAR_REQ:
  - Drive oBlack=1 for exactly 2 cycles, then go to CLEAR_REL.
- CLEAR_REL:
  - Hold oBlack=0.
  - Wait for iDone=1, then go to IDLE.
- IDLE:
  - If iEnable=1, go to WAIT_FRAME.
- WAIT_FRAME:
  - If iEnable=0, go to IDLE. Position, direction and the first flag are retained.
  - On move_tick: go to DRAW_LX if first=1, else go to ERASE_LX.
- Pass sequence, identical for the erase and draw passes:
  - LX: drive oXY_Coord=x and oLoadX=1 for 2 cycles.
  - LX_REL: drive oLoadX=0 for 1 cycle; oXY_Coord stays x.
  - PY: drive oXY_Coord=y, oColour=pass colour and oPlotBox=1 for 2 cycles.
  - PY_REL: drive oPlotBox=0; coord and colour stay stable.
  - Stay in PY_REL until iDone=1.
  - Pass colour is 3'b000 for erase and the latched iColour for draw.
- After the erase pass:
  - MOVE (1 cycle) applies the bounce/step rule, then go to DRAW_LX.
- After the draw pass:
  - Clear first, then go to WAIT_FRAME.
- Bounce/step rule, per axis (shown for x; y uses Y_RANGE and dy):
  - dx=+1 and x==X_RANGE: dx becomes -1, x becomes x-1.
  - dx=-1 and x==0: dx becomes +1, x becomes 1.
  - Otherwise x becomes x+dx.
  - Both axes update in the same cycle.
  - A corner hit reverses both directions.
- iDone is ignored outside CLEAR_REL and PY_REL.
- iDone is treated as a level: the state advances on the first cycle it is seen high.
- iColour is latched on entry to DRAW_LX. Changes during a pass do not affect it.
- oBlack is asserted only in CLEAR_REQ.
- At most one strobe is high in any cycle.

Frame divider:
- A cycle counter runs 0..FRAME_CYCLES-1 and wraps; frame_tick is the wrap cycle.
- A frame counter advances on frame_tick over 0..FRAMES_PER_MOVE-1; move_tick is its wrap.
- The divider runs continuously regardless of state.
- A move_tick that arrives while the animator is busy is dropped. It is not queued.

Widths:
- x and y are 7-bit unsigned.
- Comparisons and steps are unsigned with explicit edge checks, so x and y never wrap.

Decomposition:
- Package box_anim_pkg:
  - state enum: CLEAR_REQ, CLEAR_REL, IDLE, WAIT_FRAME, ERASE_LX, ERASE_LX_REL, ERASE_PY, ERASE_PY_REL, MOVE, DRAW_LX, DRAW_LX_REL, DRAW_PY, DRAW_PY_REL.
  - BOX_SIZE=4.
  - STROBE_CYCLES=2.
- Sub-module frame_tick_gen (FRAME_CYCLES, FRAMES_PER_MOVE): outputs the single-cycle frame_tick and move_tick.

Test Plan:
- Power-up clear. Stimulus: reset, then iDone pulse 10 cycles later. Required: oBlack high for exactly 2 cycles; state reaches IDLE 1 cycle after iDone; oLoadX and oPlotBox stay low throughout.
- First draw. Stimulus: FRAME_CYCLES=4, FRAMES_PER_MOVE=2, iEnable=1, iColour=3'b101. Required:
  - After move_tick, no erase pass occurs.
  - oLoadX is high 2 cycles with coord 0.
  - oPlotBox is high 2 cycles with coord 0 and oColour=101.
  - The block waits for iDone, then returns to WAIT_FRAME.
- Steady move from (10,20) with dx=dy=+1. Required: erase pass at coord 10/20 with colour 000, then draw pass at 11/21 with the latched colour.
- Bounce. Stimulus: x=124, dx=+1, y=0, dy=-1. Required: new position (123,1), dx=-1, dy=+1.
- Disable and busy tick. Stimulus:
  - Drop iEnable in WAIT_FRAME: block goes to IDLE, position held; re-enable resumes with an erase pass.
  - Let a move_tick arrive during PY_REL: it is dropped (no second pass).
- Async reset during DRAW_PY. Required: all outputs 0 within the same cycle, no clock edge needed; restart in CLEAR_REQ at (X_INIT, Y_INIT).
